// File: rtl/clock_switch_pkg.sv
// -----------------------------------------------------------------------------
// clock_switch_pkg
// Shared definitions for the clock-switch sequencer:
//   state_t    - sequencer FSM states (IDLE, CHECK, SWITCH, DONE, ERR)
//   SEL_CLK_A  - mux select value choosing clk_a
//   SEL_CLK_B  - mux select value choosing clk_b (the always-on clock)
//   max3()     - helper used to size the shared counter width
// -----------------------------------------------------------------------------
package clock_switch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SWITCH = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic SEL_CLK_A = 1'b1;
    localparam logic SEL_CLK_B = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/clk_activity_det.sv
// -----------------------------------------------------------------------------
// clk_activity_det
// Liveness detector for clk_a, observed from the clk_b domain. A toggle flop
// in clk_a flips on every clk_a rising edge; clk_b brings it across through a
// two-flop synchroniser and compares it with a history flop. Each toggle that
// is seen yields a single-cycle act_pulse in clk_b. A clk_a faster than clk_b
// undersamples but still produces pulses, which is enough to prove liveness.
// This is the only logic in the block that crosses clock domains.
//
// Ports:
//   clk_a     in  monitored clock
//   clk_b     in  controller clock
//   rst_n     in  asynchronous active-low reset (both domains)
//   act_pulse out one clk_b-cycle pulse per observed clk_a toggle
// -----------------------------------------------------------------------------
module clk_activity_det (
    input  logic clk_a,
    input  logic clk_b,
    input  logic rst_n,
    output logic act_pulse
);

    logic       tog;
    logic [1:0] sync;
    logic       hist;

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) tog <= 1'b0;
        else        tog <= ~tog;
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            hist <= 1'b0;
        end else begin
            sync <= {sync[0], tog};
            hist <= sync[1];
        end
    end

    assign act_pulse = sync[1] ^ hist;

endmodule

// File: rtl/clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clock_switch_ctrl
// Sequencer for the two-input glitch-free clock mux. Runs on clk_b (always on).
// Accepts a switch request, proves clk_a is alive before selecting it, drives
// the mux select once, waits a settle window and then pulses done.
//
// Handshake: a request is accepted on a clk_b rising edge where
// req_valid && req_ready; req_sel is captured on that edge. req_ready is high
// only while the FSM is idle with nothing pending; req_valid at any other time
// is ignored, not queued.
//
// Parameters:
//   SETTLE_CYCLES  (>=4) clk_b cycles of settle after a select change
//   ACT_EDGES      (>=1) clk_a activity pulses required before selecting clk_a
//   TIMEOUT_CYCLES        CHECK cycles allowed before failing (macro only)
//
// Configuration macro: CLK_SWITCH_TIMEOUT_EN
//   defined   - CHECK timer built; no activity within TIMEOUT_CYCLES -> ERR
//   undefined - no timer, err tied low, CHECK waits until activity or reset
//
// Ports:
//   clk_b      in  controller clock        rst_n     in  async active-low reset
//   clk_a      in  monitored clock         req_valid in  switch request
//   req_sel    in  target (1 = clk_a)      req_ready out request can be taken
//   clk_sel    out mux select              busy      out FSM not idle
//   done       out completion pulse        err       out failure pulse
// -----------------------------------------------------------------------------
module clock_switch_ctrl
    import clock_switch_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int ACT_EDGES      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_b,
    input  logic rst_n,
    input  logic clk_a,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic clk_sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CW = $clog2(max3(SETTLE_CYCLES, TIMEOUT_CYCLES, ACT_EDGES) + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] ACT_MAX    = CW'(ACT_EDGES);

    state_t        state;
    state_t        state_nxt;
    logic          tgt;
    logic [1:0]    pend;
    logic          accept;
    logic          act_pulse;
    logic [CW-1:0] act_cnt;
    logic [CW-1:0] settle_cnt;

    clk_activity_det u_act_det (
        .clk_a     (clk_a),
        .clk_b     (clk_b),
        .rst_n     (rst_n),
        .act_pulse (act_pulse)
    );

    assign req_ready = (state == ST_IDLE) && (pend == 2'b00);
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // pend[0]: the cycle after acceptance, when the captured target is decoded.
    // pend[1]: a same-target request spends one more cycle in IDLE so that its
    // done lands two cycles after acceptance.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pend    <= 2'b00;
            tgt     <= SEL_CLK_B;
            clk_sel <= SEL_CLK_B;
        end else begin
            state   <= state_nxt;
            pend[0] <= accept;
            pend[1] <= pend[0] && (tgt == clk_sel);
            if (accept) tgt <= req_sel;
            // The select moves only on the edge that enters SWITCH.
            if ((state_nxt == ST_SWITCH) && (state != ST_SWITCH)) clk_sel <= tgt;
        end
    end

`ifdef CLK_SWITCH_TIMEOUT_EN
    // tmr holds the number of CHECK cycles already completed; the cycle in
    // which it equals TMO_LAST is the final allowed CHECK cycle.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmr;

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n)                  tmr <= '0;
        else if (state != ST_CHECK)  tmr <= '0;
        else if (tmr != TMO_LAST)    tmr <= tmr + CW'(1);
    end

    assign err = (state == ST_ERR);
`else
    assign err = 1'b0;
`endif

    // Counters clear whenever their state is not active, so they start at zero
    // on entry, and saturate instead of wrapping.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (state != ST_CHECK)                  act_cnt <= '0;
            else if (act_pulse && act_cnt != ACT_MAX) act_cnt <= act_cnt + CW'(1);

            if (state != ST_SWITCH)                 settle_cnt <= '0;
            else if (settle_cnt != SETTLE_MAX)      settle_cnt <= settle_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pend[1]) begin
                    state_nxt = ST_DONE;
                end else if (pend[0] && (tgt != clk_sel)) begin
                    state_nxt = (tgt == SEL_CLK_A) ? ST_CHECK : ST_SWITCH;
                end
            end
            ST_CHECK: begin
                // Activity is tested first so it wins over a same-cycle timeout.
                if (act_cnt == ACT_MAX) begin
                    state_nxt = ST_SWITCH;
                end
`ifdef CLK_SWITCH_TIMEOUT_EN
                else if (tmr == TMO_LAST) begin
                    state_nxt = ST_ERR;
                end
`endif
            end
            ST_SWITCH: begin
                if (settle_cnt == SETTLE_MAX) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_switch_ctrl
// Self-checking bench for clock_switch_ctrl. Latencies are counted in clk_b
// cycles from the accepting edge: index n is the sample on the falling edge
// that follows n further rising edges (n = 0 is the half-cycle right after
// acceptance). Expected completion latencies are pushed to exp_q when a
// request is driven and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_clock_switch_ctrl;

    localparam int SETTLE  = 8;
    localparam int ACT     = 2;
    localparam int TIMEOUT = 16;

    logic clk_b;
    logic clk_a;
    logic a_en;
    logic rst_n;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic clk_sel;
    logic busy;
    logic done;
    logic err;

    int checks;
    int fails;
    logic [15:0] exp_q[$];

    clock_switch_ctrl #(
        .SETTLE_CYCLES  (SETTLE),
        .ACT_EDGES      (ACT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_b     (clk_b),
        .rst_n     (rst_n),
        .clk_a     (clk_a),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .clk_sel   (clk_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_b = 1'b0;
        forever #5 clk_b = ~clk_b;
    end

    // clk_a runs at one third of the clk_b rate when enabled, offset in phase.
    initial begin
        clk_a = 1'b0;
        #2;
        forever begin
            #15;
            if (a_en) clk_a = ~clk_a;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_b);
    endtask

    // ---------------- drivers ----------------
    // Presents a request and returns just after the accepting edge.
    task automatic send_req(input logic sel);
        int k;
        @(negedge clk_b);
        req_valid = 1'b1;
        req_sel   = sel;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk_b);
            k++;
        end
        checks++;
        if (k >= 50) begin
            $display("FAIL send_req_ready: req_ready=%b after %0d cycles, required 1", req_ready, k);
            fails++;
        end
        @(posedge clk_b);
        #1;
        req_valid = 1'b0;
    endtask

    // Monitors from just after an accepting edge until done/err (plus one
    // cycle to see req_ready come back) or until the budget runs out.
    task automatic run_to_end(input int budget, output int t_done, output int t_err,
                              output int t_rise, output int t_fall, output int n_chg,
                              output int rdy_viol, output logic rdy_back);
        logic prev_sel;
        prev_sel = clk_sel;
        t_done = -1; t_err = -1; t_rise = -1; t_fall = -1;
        n_chg = 0; rdy_viol = 0; rdy_back = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_b);
            if (clk_sel !== prev_sel) begin
                n_chg++;
                if (clk_sel === 1'b1) t_rise = n;
                else                  t_fall = n;
                prev_sel = clk_sel;
            end
            if (req_ready !== 1'b0) rdy_viol++;
            if (done === 1'b1) t_done = n;
            if (err === 1'b1)  t_err = n;
            if (t_done >= 0 || t_err >= 0) begin
                @(negedge clk_b);
                rdy_back = req_ready;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0; a_en = 1'b0;
        wait_cycles(3);
        checks++;
        if (clk_sel !== 1'b0) begin
            $display("FAIL reset_clk_sel_in_reset: got %b required 0", clk_sel); fails++;
        end
        rst_n = 1'b1;
        @(negedge clk_b);
        checks++;
        if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b required 1", req_ready); fails++; end
        checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); fails++; end
        checks++;
        if (clk_sel !== 1'b0) begin $display("FAIL reset_clk_sel: got %b required 0", clk_sel); fails++; end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL reset_pulses: done=%b err=%b required 0 0", done, err); fails++;
        end
    endtask

    task automatic test_same_target;
        int td, te, tr, tf, nc, rv;
        logic rb;
        logic [15:0] e;
        send_req(1'b0);
        exp_q.push_back(16'd2);
        run_to_end(40, td, te, tr, tf, nc, rv, rb);
        e = exp_q.pop_front();
        checks++;
        if (td !== int'(e)) begin $display("FAIL same_done_latency: got %0d required %0d", td, e); fails++; end
        checks++;
        if (nc !== 0 || clk_sel !== 1'b0) begin
            $display("FAIL same_clk_sel: changes=%0d clk_sel=%b required 0 0", nc, clk_sel); fails++;
        end
        checks++;
        if (te !== -1) begin $display("FAIL same_no_err: err at %0d required none", te); fails++; end
        checks++;
        if (rv !== 0 || rb !== 1'b1) begin
            $display("FAIL same_ready: low_viol=%0d back=%b required 0 1", rv, rb); fails++;
        end
    endtask

    task automatic test_switch_a;
        int td, te, tr, tf, nc, rv;
        logic rb;
        logic [15:0] e;
        a_en = 1'b1;
        wait_cycles(10);
        send_req(1'b1);
        exp_q.push_back(16'(SETTLE + 1));
        run_to_end(200, td, te, tr, tf, nc, rv, rb);
        e = exp_q.pop_front();
        checks++;
        if (nc !== 1 || tr < 0) begin
            $display("FAIL a_sel_rise: changes=%0d rise_at=%0d required 1 rise", nc, tr); fails++;
        end
        checks++;
        if (tr < 4 || tr > 20) begin $display("FAIL a_check_len: rise_at=%0d required 4..20", tr); fails++; end
        checks++;
        if (td - tr !== int'(e)) begin
            $display("FAIL a_settle: done-rise=%0d required %0d", td - tr, e); fails++;
        end
        checks++;
        if (rv !== 0 || rb !== 1'b1) begin
            $display("FAIL a_ready: low_viol=%0d back=%b required 0 1", rv, rb); fails++;
        end
    endtask

    task automatic test_switch_b;
        int td, te, tr, tf, nc, rv;
        logic rb;
        logic [15:0] e;
        send_req(1'b0);
        exp_q.push_back(16'(SETTLE + 2));
        run_to_end(60, td, te, tr, tf, nc, rv, rb);
        e = exp_q.pop_front();
        checks++;
        if (tf !== 1 || nc !== 1) begin
            $display("FAIL b_fall: fall_at=%0d changes=%0d required 1 1", tf, nc); fails++;
        end
        checks++;
        if (td !== int'(e)) begin $display("FAIL b_done_latency: got %0d required %0d", td, e); fails++; end
        checks++;
        if (rb !== 1'b1) begin $display("FAIL b_ready_back: got %b required 1", rb); fails++; end
    endtask

    task automatic test_back_to_back;
        int k, d, td, te, tr, tf, nc, rv;
        logic early, rb;
        logic [15:0] e;
        send_req(1'b1);
        k = 0;
        while (clk_sel !== 1'b1 && k < 100) begin
            @(negedge clk_b);
            k++;
        end
        checks++;
        if (k >= 100) begin $display("FAIL b2b_rise: clk_sel=%b required 1", clk_sel); fails++; end
        // Opposite request held while the first one is still settling.
        req_valid = 1'b1;
        req_sel   = 1'b0;
        d = -1;
        early = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) begin d = n; break; end
            if (req_ready !== 1'b0) early = 1'b1;
            @(negedge clk_b);
        end
        checks++;
        if (d < 0 || early !== 1'b0 || clk_sel !== 1'b1) begin
            $display("FAIL b2b_ignored: done_at=%0d ready_early=%b clk_sel=%b required >=0 0 1", d, early, clk_sel);
            fails++;
        end
        @(negedge clk_b);
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_ready_return: ready=%b done=%b required 1 0", req_ready, done); fails++;
        end
        @(posedge clk_b);
        #1;
        req_valid = 1'b0;
        exp_q.push_back(16'(SETTLE + 2));
        run_to_end(60, td, te, tr, tf, nc, rv, rb);
        e = exp_q.pop_front();
        checks++;
        if (tf !== 1 || td !== int'(e)) begin
            $display("FAIL b2b_second: fall_at=%0d done_at=%0d required 1 %0d", tf, td, e); fails++;
        end
    endtask

    task automatic test_stopped_clk_a;
        int td, te, tr, tf, nc, rv;
        logic rb;
        a_en = 1'b0;
        wait_cycles(10);
        send_req(1'b1);
`ifdef CLK_SWITCH_TIMEOUT_EN
        run_to_end(100, td, te, tr, tf, nc, rv, rb);
        checks++;
        if (te !== TIMEOUT + 1 || td !== -1) begin
            $display("FAIL timeout_err: err_at=%0d done_at=%0d required %0d -1", te, td, TIMEOUT + 1); fails++;
        end
        checks++;
        if (nc !== 0 || clk_sel !== 1'b0 || rb !== 1'b1) begin
            $display("FAIL timeout_state: changes=%0d clk_sel=%b ready=%b required 0 0 1", nc, clk_sel, rb);
            fails++;
        end
`else
        run_to_end(64, td, te, tr, tf, nc, rv, rb);
        checks++;
        if (td !== -1 || te !== -1) begin
            $display("FAIL stall_no_finish: done_at=%0d err_at=%0d required -1 -1", td, te); fails++;
        end
        checks++;
        if (busy !== 1'b1 || clk_sel !== 1'b0) begin
            $display("FAIL stall_state: busy=%b clk_sel=%b required 1 0", busy, clk_sel); fails++;
        end
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        @(negedge clk_b);
        checks++;
        if (req_ready !== 1'b1) begin $display("FAIL stall_reset_exit: ready=%b required 1", req_ready); fails++; end
`endif
    endtask

    task automatic test_reset_mid_switch;
        int k;
        logic bad;
        a_en = 1'b1;
        wait_cycles(10);
        send_req(1'b1);
        k = 0;
        while (clk_sel !== 1'b1 && k < 100) begin
            @(negedge clk_b);
            k++;
        end
        wait_cycles(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (clk_sel !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL rst_mid_outputs: clk_sel=%b busy=%b done=%b err=%b required 0 0 0 0",
                     clk_sel, busy, done, err);
            fails++;
        end
        wait_cycles(3);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_b);
            if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1 || clk_sel !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            $display("FAIL rst_mid_after: done=%b err=%b ready=%b clk_sel=%b required 0 0 1 0",
                     done, err, req_ready, clk_sel);
            fails++;
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_same_target();
        test_switch_a();
        test_switch_b();
        test_back_to_back();
        test_stopped_clk_a();
        test_reset_mid_switch();
        checks++;
        if (exp_q.size() !== 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); fails++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
